// File: rtl/bisc_mvm_sequencer.sv
// bisc_mvm_sequencer
// Job-level controller for one BISC matrix-vector multiply lane. A job walks
// num_cols_m1+1 input-vector columns; each column gets a one-cycle operand
// LOAD followed by a RUN of SC_LEN enabled cycles that step the bit-selector
// counter. After the last column the MAC pipeline is drained for DRAIN_CYC
// cycles, then a one-cycle done pulse is issued. The selector's end-of-stream
// flag is cross-checked against the local cycle count (sticky seq_err).
//
// Ports:
//   clock, reset        - clock, asynchronous active-low reset
//   start, num_cols_m1  - job request and column count minus one (IDLE only)
//   hold                - downstream stall, freezes RUN progress
//   abort               - synchronous job cancel
//   zero_select         - end-of-stream flag from the selector counter
//   busy, load_en, col_addr, acc_clear - job status / operand load control
//   sel_reset, sel_enable               - selector counter control
//   done, seq_err                       - completion pulse, sticky mismatch
module bisc_mvm_sequencer #(
    parameter int unsigned BIN_LEN   = 8,
    parameter int unsigned MAX_COLS  = 16,
    parameter int unsigned DRAIN_CYC = 2,
    parameter int unsigned COL_W     = $clog2(MAX_COLS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [COL_W-1:0] num_cols_m1,
    input  logic             hold,
    input  logic             abort,
    input  logic             zero_select,
    output logic             busy,
    output logic             load_en,
    output logic [COL_W-1:0] col_addr,
    output logic             acc_clear,
    output logic             sel_reset,
    output logic             sel_enable,
    output logic             done,
    output logic             seq_err
);

    localparam int unsigned SC_LEN = 1 << BIN_LEN;
    localparam int unsigned RUN_W  = BIN_LEN + 1;
    localparam int unsigned DRN_W  = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q,     state_d;
    logic [COL_W-1:0] cols_m1_q,   cols_m1_d;
    logic [COL_W-1:0] col_addr_q,  col_addr_d;
    logic [RUN_W-1:0] run_cnt_q,   run_cnt_d;
    logic [DRN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic             seq_err_q,   seq_err_d;
    logic             busy_q,      busy_d;
    logic             load_en_q,   load_en_d;
    logic             acc_clear_q, acc_clear_d;
    logic             sel_reset_q, sel_reset_d;
    logic             done_q,      done_d;

    logic             run_en;
    logic             last_beat;

    // Selector advances on every un-stalled RUN cycle.
    assign run_en     = (state_q == S_RUN) && !hold;
    assign last_beat  = (run_cnt_q == RUN_W'(SC_LEN - 1));
    assign sel_enable = run_en;

    // Next-state, counters and registered output decode.
    always_comb begin
        state_d     = state_q;
        cols_m1_d   = cols_m1_q;
        col_addr_d  = col_addr_q;
        run_cnt_d   = run_cnt_q;
        drain_cnt_d = drain_cnt_q;
        seq_err_d   = seq_err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cols_m1_d  = num_cols_m1;
                    col_addr_d = '0;
                    seq_err_d  = 1'b0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                run_cnt_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (!hold) begin
                    run_cnt_d = run_cnt_q + RUN_W'(1);
                    // Selector must flag end-of-stream exactly on the last beat.
                    if (zero_select != last_beat) begin
                        seq_err_d = 1'b1;
                    end
                    if (last_beat) begin
                        if (col_addr_q == cols_m1_q) begin
                            drain_cnt_d = '0;
                            state_d     = S_DRAIN;
                        end else begin
                            col_addr_d = col_addr_q + COL_W'(1);
                            state_d    = S_LOAD;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DRN_W'(DRAIN_CYC - 1)) begin
                    state_d = S_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRN_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides any transition, including the RUN exit; the column
        // index stays where it was and seq_err is kept for inspection.
        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            col_addr_d = col_addr_q;
        end

        busy_d      = (state_d != S_IDLE);
        load_en_d   = (state_d == S_LOAD);
        acc_clear_d = (state_d == S_LOAD) && (col_addr_d == '0);
        sel_reset_d = (state_d == S_IDLE) || (state_d == S_LOAD);
        done_d      = (state_d == S_DONE);
    end

    // State, counters and output flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cols_m1_q   <= '0;
            col_addr_q  <= '0;
            run_cnt_q   <= '0;
            drain_cnt_q <= '0;
            seq_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            load_en_q   <= 1'b0;
            acc_clear_q <= 1'b0;
            sel_reset_q <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cols_m1_q   <= cols_m1_d;
            col_addr_q  <= col_addr_d;
            run_cnt_q   <= run_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            seq_err_q   <= seq_err_d;
            busy_q      <= busy_d;
            load_en_q   <= load_en_d;
            acc_clear_q <= acc_clear_d;
            sel_reset_q <= sel_reset_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign load_en   = load_en_q;
    assign col_addr  = col_addr_q;
    assign acc_clear = acc_clear_q;
    assign sel_reset = sel_reset_q;
    assign done      = done_q;
    assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_bisc_mvm_sequencer.sv
// Directed bench for bisc_mvm_sequencer. A small selector-counter model
// drives zero_select from sel_reset/sel_enable, as the real datapath would.
// Cycle c of a job is counted from the cycle start is driven (c = 0).
// Status vector order: {busy, load_en, acc_clear, sel_reset, sel_enable, done, seq_err}.
module tb_bisc_mvm_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] num_cols_m1;
    logic       hold;
    logic       abort;
    logic       zero_select;
    logic       busy, load_en, acc_clear, sel_reset, sel_enable, done, seq_err;
    logic [3:0] col_addr;

    logic [7:0] sel_cnt;
    logic       zs_force;
    int         n_cmp = 0;
    int         n_fail = 0;

    bisc_mvm_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .num_cols_m1 (num_cols_m1),
        .hold        (hold),
        .abort       (abort),
        .zero_select (zero_select),
        .busy        (busy),
        .load_en     (load_en),
        .col_addr    (col_addr),
        .acc_clear   (acc_clear),
        .sel_reset   (sel_reset),
        .sel_enable  (sel_enable),
        .done        (done),
        .seq_err     (seq_err)
    );

    always #5 clock = ~clock;

    // Selector counter model: flags end-of-stream at count 255.
    always @(posedge clock) begin
        if (sel_reset)       sel_cnt <= 8'd0;
        else if (sel_enable) sel_cnt <= sel_cnt + 8'd1;
    end
    assign zero_select = (sel_cnt == 8'd255) || zs_force;

    task automatic test_reset();
        logic [6:0] obs;
        reset = 1'b0;
        start = 1'b0; num_cols_m1 = 4'd0; hold = 1'b0; abort = 1'b0; zs_force = 1'b0;
        repeat (3) @(negedge clock);
        obs = {busy, load_en, acc_clear, sel_reset, sel_enable, done, seq_err};
        n_cmp++;
        if (obs !== 7'b0001000) begin
            n_fail++;
            $display("FAIL reset_status got %b exp %b", obs, 7'b0001000);
        end
        n_cmp++;
        if (col_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_col_addr got %0d exp 0", col_addr);
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_single_col();
        logic [6:0] obs, exp;
        @(negedge clock); start = 1'b1; num_cols_m1 = 4'd0;
        for (int c = 1; c <= 261; c++) begin
            @(negedge clock); start = 1'b0; #1;
            if (c == 1)        exp = 7'b1111000;
            else if (c <= 257) exp = 7'b1000100;
            else if (c <= 259) exp = 7'b1000000;
            else if (c == 260) exp = 7'b1000010;
            else               exp = 7'b0001000;
            obs = {busy, load_en, acc_clear, sel_reset, sel_enable, done, seq_err};
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL single_col c=%0d got %b exp %b", c, obs, exp);
            end
        end
    endtask

    task automatic test_three_cols();
        logic [6:0] obs, exp;
        logic [3:0] exp_col;
        int         ph;
        @(negedge clock); start = 1'b1; num_cols_m1 = 4'd2;
        for (int c = 1; c <= 775; c++) begin
            @(negedge clock); start = 1'b0; #1;
            ph = (c - 1) % 257;
            if (c <= 771) begin
                exp_col = 4'((c - 1) / 257);
                exp = {1'b1, ph == 0, c == 1, ph == 0, ph != 0, 2'b00};
            end else begin
                exp_col = 4'd2;
                if (c <= 773)      exp = 7'b1000000;
                else if (c == 774) exp = 7'b1000010;
                else               exp = 7'b0001000;
            end
            obs = {busy, load_en, acc_clear, sel_reset, sel_enable, done, seq_err};
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL three_cols c=%0d got %b exp %b", c, obs, exp);
            end
            n_cmp++;
            if (col_addr !== exp_col) begin
                n_fail++;
                $display("FAIL three_cols_addr c=%0d got %0d exp %0d", c, col_addr, exp_col);
            end
        end
    endtask

    task automatic test_hold();
        logic [6:0] obs, exp;
        @(negedge clock); start = 1'b1; num_cols_m1 = 4'd0;
        for (int c = 1; c <= 266; c++) begin
            @(negedge clock); start = 1'b0;
            hold = (c >= 50 && c <= 54); #1;
            if (c == 1)                 exp = 7'b1111000;
            else if (c >= 50 && c <= 54) exp = 7'b1000000;
            else if (c <= 262)          exp = 7'b1000100;
            else if (c <= 264)          exp = 7'b1000000;
            else if (c == 265)          exp = 7'b1000010;
            else                        exp = 7'b0001000;
            obs = {busy, load_en, acc_clear, sel_reset, sel_enable, done, seq_err};
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL hold c=%0d got %b exp %b", c, obs, exp);
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_abort();
        logic [6:0] obs;
        @(negedge clock); start = 1'b1; num_cols_m1 = 4'd3;
        // Column 1 LOAD at c=258, RUN cycle 100 at c=359.
        for (int c = 1; c <= 623; c++) begin
            @(negedge clock);
            start = (c == 362);
            abort = (c == 359) || (c == 362);
            if (c == 362) num_cols_m1 = 4'd0;
            #1;
            obs = {busy, load_en, acc_clear, sel_reset, sel_enable, done, seq_err};
            if (c == 360) begin
                n_cmp++;
                if (obs !== 7'b0001000) begin
                    n_fail++;
                    $display("FAIL abort_idle c=%0d got %b exp %b", c, obs, 7'b0001000);
                end
            end else if (c == 363) begin
                n_cmp++;
                if (obs !== 7'b1111000 || col_addr !== 4'd0) begin
                    n_fail++;
                    $display("FAIL abort_restart_load got %b/%0d exp %b/0", obs, col_addr, 7'b1111000);
                end
            end else begin
                n_cmp++;
                if (done !== (c == 622)) begin
                    n_fail++;
                    $display("FAIL abort_done c=%0d got %b exp %b", c, done, c == 622);
                end
            end
        end
        n_cmp++;
        if (busy !== 1'b0 || seq_err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_end got busy=%b seq_err=%b exp 0/0", busy, seq_err);
        end
    endtask

    task automatic test_mismatch();
        logic exp_err;
        @(negedge clock); start = 1'b1; num_cols_m1 = 4'd0;
        // RUN cycle 50 at c=52; a second job is requested in the first IDLE cycle.
        for (int c = 1; c <= 522; c++) begin
            @(negedge clock);
            start = (c == 261);
            zs_force = (c == 52);
            #1;
            exp_err = (c >= 53 && c <= 261);
            n_cmp++;
            if (seq_err !== exp_err) begin
                n_fail++;
                $display("FAIL mismatch_err c=%0d got %b exp %b", c, seq_err, exp_err);
            end
            n_cmp++;
            if (done !== (c == 260 || c == 521) || load_en !== (c == 1 || c == 262)) begin
                n_fail++;
                $display("FAIL mismatch_seq c=%0d got done=%b load=%b", c, done, load_en);
            end
        end
        zs_force = 1'b0;
    endtask

    task automatic test_start_while_busy();
        @(negedge clock); start = 1'b1; num_cols_m1 = 4'd1;
        for (int c = 1; c <= 519; c++) begin
            @(negedge clock);
            start = (c == 5 || c == 258 || c == 517);
            num_cols_m1 = 4'd0;
            #1;
            n_cmp++;
            if (load_en !== (c == 1 || c == 258) || done !== (c == 517) || busy !== (c <= 517)) begin
                n_fail++;
                $display("FAIL busy_start c=%0d got load=%b done=%b busy=%b", c, load_en, done, busy);
            end
            if (c == 258) begin
                n_cmp++;
                if (col_addr !== 4'd1 || acc_clear !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_start_col1 got addr=%0d clr=%b exp 1/0", col_addr, acc_clear);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [6:0] obs;
        @(negedge clock); start = 1'b1; num_cols_m1 = 4'd2;
        repeat (100) begin @(negedge clock); start = 1'b0; end
        #2 reset = 1'b0;
        #1;
        obs = {busy, load_en, acc_clear, sel_reset, sel_enable, done, seq_err};
        n_cmp++;
        if (obs !== 7'b0001000 || col_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset got %b/%0d exp %b/0", obs, col_addr, 7'b0001000);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock); #1;
            n_cmp++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL async_reset_after c=%0d got busy=%b done=%b exp 0/0", c, busy, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_col();
        test_three_cols();
        test_hold();
        test_abort();
        test_mismatch();
        test_start_while_busy();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
